// File: rtl/uart_pkg.sv
// Shared types and width helpers for the UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_e;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Write FIFO for the UART transmitter; wrap-bit pointers give full/empty straight from registers.
module uart_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              rd,
   output logic [DATA_W-1:0] rdata,
   output logic              full,
   output logic              empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]       wp_q, rp_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic              push, pop;

   assign empty = (wp_q == rp_q);
   assign full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
   // A write while full is dropped even if a pop happens on the same edge.
   assign push  = wr & ~full;
   assign pop   = rd & ~empty;
   assign rdata = mem_q[rp_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp_q <= '0;
         rp_q <= '0;
      end else begin
         if (push) wp_q <= wp_q + 1'b1;
         if (pop)  rp_q <= rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with write FIFO and baud divider; frames run back-to-back while data is queued.
// Define UART_TX_PARITY_EN to insert a parity bit (sense set by PARITY_ODD) after the data bits.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr,
   input  logic [DATA_W-1:0] data,
   output logic              full,
   output logic              empty,
   output logic              busy,
   output logic              ovf,
   output logic              txd
);

   localparam int BAUD_W = cnt_w(CLKS_PER_BIT);
   localparam int BIT_W  = cnt_w(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   state_e              state_q, state_d;
   logic [BAUD_W-1:0]   baud_q, baud_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [DATA_W-1:0]   shift_q, shift_d;
   logic                txd_q, txd_d;
   logic                ovf_q;
   logic                pop, bit_end;
   logic [DATA_W-1:0]   fifo_rdata;
`ifdef UART_TX_PARITY_EN
   logic                par_q, par_d;
`endif

   uart_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr    (wr),
      .wdata (data),
      .rd    (pop),
      .rdata (fifo_rdata),
      .full  (full),
      .empty (empty)
   );

   assign bit_end = (baud_q == BAUD_LAST);

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q + 1'b1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = ST_START;
            end
         end
         ST_START: if (bit_end) begin
            baud_d  = '0;
            state_d = ST_DATA;
         end
         ST_DATA: if (bit_end) begin
            baud_d  = '0;
            shift_d = shift_q >> 1;
            if (bit_q == DATA_LAST) begin
               bit_d = '0;
`ifdef UART_TX_PARITY_EN
               state_d = ST_PARITY;
`else
               state_d = ST_STOP;
`endif
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: if (bit_end) begin
            baud_d  = '0;
            state_d = ST_STOP;
         end
`endif
         ST_STOP: if (bit_end) begin
            baud_d = '0;
            // Last stop cycle: chain straight into the next start bit when data waits.
            if (bit_q == STOP_LAST) begin
               bit_d = '0;
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = ST_START;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               bit_d = bit_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (pop) begin
         shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
         par_d   = (^fifo_rdata) ^ 1'(PARITY_ODD);
`endif
      end
   end

   always_comb begin
      txd_d = 1'b1;
      case (state_q)
         ST_START:  txd_d = 1'b0;
         ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: txd_d = par_q;
`endif
         default:   txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         txd_q   <= 1'b1;
         ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         txd_q   <= txd_d;
         ovf_q   <= wr & full;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign ovf  = ovf_q;
   assign txd  = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, frame bits, back-to-back, overflow, reset mid-frame.
module tb_uart_tx_fifo;

   localparam int DW    = 8;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int SB    = 1;
   localparam int PODD  = 0;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int TMO = 200;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          wr  = 1'b0;
   logic [DW-1:0] data = '0;
   logic          full, empty, busy, ovf, txd;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(
      .DATA_W(DW), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
      .STOP_BITS(SB), .PARITY_ODD(PODD)
   ) dut (
      .clk(clk), .rst(rst), .wr(wr), .data(data),
      .full(full), .empty(empty), .busy(busy), .ovf(ovf), .txd(txd)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Called on a negedge; waits for a start bit, then samples one cycle into each bit.
   task automatic rx(output logic [11:0] bits, output int waited);
      bits   = '0;
      waited = 0;
      while (txd !== 1'b0 && waited < TMO) begin
         tick();
         waited++;
      end
      if (waited < TMO)
         for (int k = 0; k < NB; k++) begin
            tick();
            bits[k] = txd;
            tick(); tick(); tick();
         end
   endtask

   task automatic rx_chk(input string tag, input logic [DW-1:0] d, output int waited);
      logic [11:0] bits, exp_bits;
      rx(bits, waited);
      exp_bits        = '0;
      exp_bits[DW:1]  = d;
      if (NB == 11) exp_bits[9] = (^d) ^ 1'(PODD);
      exp_bits[NB-1]  = 1'b1;
      chk({tag, "_tmo"}, 32'(waited < TMO), 32'd1);
      chk({tag, "_bits"}, 32'(bits), 32'(exp_bits));
   endtask

   task automatic busy_width(output int w);
      int g = 0;
      w = 0;
      while (busy !== 1'b1 && g < TMO) begin tick(); g++; end
      while (busy === 1'b1 && w < TMO) begin tick(); w++; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          w, z;
      logic [11:0] bits;

      tick(); tick();
      chk("rst_full",  32'(full),  32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_busy",  32'(busy),  32'd0);
      chk("rst_ovf",   32'(ovf),   32'd0);
      chk("rst_txd",   32'(txd),   32'd1);
      rst = 1'b1;
      tick();

      // single byte: write at edge N, txd falls after edge N+2
      wr = 1'b1; data = 8'hA5; tick(); wr = 1'b0;
      chk("a5_empty", 32'(empty), 32'd0);
      chk("a5_txd_n0", 32'(txd), 32'd1);
      tick();
      chk("a5_txd_n1", 32'(txd), 32'd1);
      chk("a5_busy",   32'(busy), 32'd1);
      tick();
      chk("a5_fall",   32'(txd), 32'd0);
      rx_chk("a5", 8'hA5, w);
      chk("a5_wait", 32'(w), 32'd0);
      chk("a5_idle_busy", 32'(busy), 32'd0);
      chk("a5_idle_txd",  32'(txd),  32'd1);

      wr = 1'b1; data = 8'h3C; tick(); wr = 1'b0;
      busy_width(w);
      chk("busy_width", 32'(w), 32'(CPB * NB));
      repeat (4) tick();

      // burst of three, no idle gap between frames
      wr = 1'b1; data = 8'h00; tick(); data = 8'hFF; tick(); data = 8'h55; tick(); wr = 1'b0;
      rx_chk("b0", 8'h00, w);
      chk("b0_gap", 32'(w), 32'd0);
      chk("b1_empty_pre", 32'(empty), 32'd0);
      rx_chk("b1", 8'hFF, w);
      chk("b1_gap", 32'(w), 32'd0);
      chk("b2_empty", 32'(empty), 32'd1);
      rx_chk("b2", 8'h55, w);
      chk("b2_gap", 32'(w), 32'd0);
      chk("b_busy_end", 32'(busy), 32'd0);

      // overflow: 0xFF in flight, five writes, fifth dropped
      wr = 1'b1; data = 8'hFF; tick(); wr = 1'b0;
      repeat (10) tick();
      wr = 1'b1; data = 8'h11; tick(); data = 8'h22; tick(); data = 8'h33; tick();
      chk("ovf_full3", 32'(full), 32'd0);
      data = 8'h44; tick();
      chk("ovf_full4", 32'(full), 32'd1);
      chk("ovf_pre",   32'(ovf),  32'd0);
      data = 8'h55; tick(); wr = 1'b0;
      chk("ovf_pulse", 32'(ovf),  32'd1);
      chk("ovf_full5", 32'(full), 32'd1);
      tick();
      chk("ovf_clear", 32'(ovf),  32'd0);
      rx_chk("o1", 8'h11, w);
      rx_chk("o2", 8'h22, w);
      chk("o2_gap", 32'(w), 32'd0);
      rx_chk("o3", 8'h33, w);
      rx_chk("o4", 8'h44, w);
      rx(bits, w);
      chk("ovf_no_fifth", 32'(w), 32'(TMO));
      chk("ovf_empty", 32'(empty), 32'd1);

      // full FIFO, write on the pop edge is still dropped
      wr = 1'b1; data = 8'hFF; tick();
      data = 8'hA1; tick(); data = 8'hA2; tick(); data = 8'hA3; tick(); data = 8'hA4; tick();
      wr = 1'b0;
      chk("fp_full", 32'(full), 32'd1);
      repeat (36) tick();
      chk("fp_full_pre", 32'(full), 32'd1);
      chk("fp_busy_pre", 32'(busy), 32'd1);
      wr = 1'b1; data = 8'hEE; tick(); wr = 1'b0;
      chk("fp_ovf",  32'(ovf),  32'd1);
      chk("fp_full_post", 32'(full), 32'd0);
      rx_chk("f1", 8'hA1, w);
      rx_chk("f2", 8'hA2, w);
      rx_chk("f3", 8'hA3, w);
      rx_chk("f4", 8'hA4, w);
      rx(bits, w);
      chk("fp_no_ee", 32'(w), 32'(TMO));

      // reset during data bit 3 of an all-zero word, with a second word queued
      wr = 1'b1; data = 8'h00; tick(); data = 8'h5A; tick(); wr = 1'b0;
      repeat (18) tick();
      chk("mr_pre_txd",   32'(txd),   32'd0);
      chk("mr_pre_empty", 32'(empty), 32'd0);
      rst = 1'b0;
      #1;
      chk("mr_txd",   32'(txd),   32'd1);
      chk("mr_empty", 32'(empty), 32'd1);
      chk("mr_busy",  32'(busy),  32'd0);
      tick();
      rst = 1'b1;
      z = 0;
      repeat (60) begin
         tick();
         if (txd !== 1'b1) z++;
      end
      chk("mr_quiet", 32'(z), 32'd0);

`ifdef UART_TX_PARITY_EN
      wr = 1'b1; data = 8'h07; tick(); wr = 1'b0;
      rx(bits, w);
      chk("par07_tmo", 32'(w < TMO), 32'd1);
      chk("par07_bit", 32'(bits[9]), 32'(1 ^ PODD));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
